alu_op_sequencer: RTL
=====================

// Module: alu_op_sequencer
// PURPOSE
//  Sequences one LC-3 operate instruction (ADD, AND, NOT) at a time through the clocked alu.
//  Per instruction: accepts it over a valid/ready handshake, reads operands from the register
//  file, drives the alu, writes the result back and updates the NZP condition-code register.
//  Sits between the fetch/decode front end and the alu/register file.
// PARAMETERS
//  ALU_LAT  1  cycles from alu inputs stable to alu out/nzp valid (1..7)
// PORTS
//  clk          in   1   system clock, all state on rising edge
//  rst_n        in   1   asynchronous active-low reset
//  instr        in   16  LC-3 instruction word
//  instr_valid  in   1   instr is presented
//  instr_ready  out  1   sequencer can accept; high only in IDLE
//  sr1_addr     out  3   regfile read port 1 address = instr[8:6]
//  sr2_addr     out  3   regfile read port 2 address = instr[2:0]
//  sr1_data     in   16  regfile read data 1, combinational
//  sr2_data     in   16  regfile read data 2, combinational
//  alu_a        out  16  alu operand a
//  alu_b        out  16  alu operand b
//  alu_opcode   out  4   alu opcode: 0001 ADD, 0101 AND, 1001 NOT
//  alu_out      in   16  alu result
//  alu_nzp      in   3   alu flags {n,z,p}
//  wb_en        out  1   regfile write strobe
//  wb_addr      out  3   destination = instr[11:9]
//  wb_data      out  16  write data = alu_out
//  cc_nzp       out  3   architectural condition codes
//  done         out  1   one-cycle pulse at instruction retirement
//  err          out  1   one-cycle pulse, illegal opcode
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE, instr_ready=1, wb_en=0, done=0, err=0,
//   cc_nzp=3'b010, alu_a/alu_b=0, alu_opcode=0000, latched IR=0. Mid-op reset aborts with no writeback.
//  FSM states:
//   IDLE   -> DECODE; transfer when instr_valid && instr_ready, IR <= instr.
//   DECODE -> opcode legal: capture A <= sr1_data, B <= operand b; go to EXEC.
//             opcode illegal: pulse err=1 and done=1; no writeback; cc unchanged; go to IDLE.
//   EXEC   -> drive alu_a=A, alu_b=B, alu_opcode=IR[15:12] for exactly ALU_LAT cycles
//             (down-counter); then go to WB.
//   WB     -> wb_en=1, wb_data=alu_out, cc_nzp <= alu_nzp, done=1; go to IDLE.
//  Operand b:
//   ADD/AND with IR[5]=1: sign-extended imm5 = {{11{IR[4]}},IR[4:0]}.
//   ADD/AND with IR[5]=0: sr2_data.
//   NOT: 16'h0000.
//  NOT ignores IR[5:0]; no check that IR[5:0]=111111.
//  Latency: acceptance in cycle N -> wb_en/done in cycle N+2+ALU_LAT.
//   Throughput is one instruction per 3+ALU_LAT cycles.
//  alu_* outputs hold their values outside EXEC; the alu result is sampled only in WB.
//  sr1_addr/sr2_addr decode from IR continuously.
//  DR may equal SR1/SR2: operands are captured in DECODE, so writeback is hazard-free.
//  instr_valid while busy is ignored (ready=0); the front end must hold the instruction.
//  wb_en, done and err are never high for more than one cycle. err implies done.
// STRUCTURE
//  Shared include lc3_defs.vh: OP_ADD/OP_AND/OP_NOT opcode constants, NZP reset value,
//   FSM state encodings (IDLE, DECODE, EXEC, WB).
//  Sub-module lc3_operand_b_mux: combinational imm5 sign-extend / sr2 / zero select.
//  The alu and register file stay external, connected at the parent level.
// TESTING
//  1) ADD reg: R1=5, R2=3, instr 0x1042 (R0=R1+R2) -> wb_en at N+3 (ALU_LAT=1), wb_addr=0,
//     wb_data=8, cc_nzp=001, done=1.
//  2) AND imm5: R1=5, instr 0x5264 (R1=R1&4) -> alu_b=0x0004, wb_data=4, cc_nzp=001.
//  3) NOT: R3=0xFFFD, instr 0x98FF (R4=~R3) -> alu_b=0, wb_data=2, cc_nzp=001.
//  4) Negative/zero:
//     - ADD imm5 -4 on R1=-3 (0x127C) -> wb_data=0xFFF9, cc_nzp=100.
//     - ADD R1=2 + R2=-2 -> wb_data=0, cc_nzp=010.
//  5) Illegal/backpressure:
//     - instr 0x0E00 -> err=done=1 at N+1, wb_en never high, cc_nzp unchanged.
//     - instr_valid held during busy -> accepted only once ready returns.
//  6) Reset in EXEC with ALU_LAT=3 -> outputs return to reset values immediately, no wb_en.
//     Repeat test 1 with ALU_LAT=3 -> done at N+5.

Source files
------------

// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for the LC-3 operate-instruction sequencer: opcodes, NZP reset value,
// FSM state encoding and the opcode legality helper.
package alu_op_sequencer_pkg;

   localparam logic [3:0] OP_ADD = 4'b0001;
   localparam logic [3:0] OP_AND = 4'b0101;
   localparam logic [3:0] OP_NOT = 4'b1001;

   localparam logic [2:0] NZP_RESET = 3'b010;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DECODE = 2'd1,
      ST_EXEC   = 2'd2,
      ST_WB     = 2'd3
   } seq_state_e;

   function automatic logic is_legal_op(input logic [3:0] op);
      logic legal;
      case (op)
         OP_ADD, OP_AND, OP_NOT: legal = 1'b1;
         default:                legal = 1'b0;
      endcase
      return legal;
   endfunction

endpackage

// File: rtl/alu_op_sequencer_operand_b_mux.sv
// Operand-b select for operate instructions: sign-extended imm5, sr2 read data, or zero for NOT.
module lc3_operand_b_mux
   import alu_op_sequencer_pkg::*;
(
   input  logic [15:0] ir,
   input  logic [15:0] sr2_data,
   output logic [15:0] opb
);

   // operand b selection from the latched instruction
   always_comb begin
      opb = 16'h0000;
      case (ir[15:12])
         OP_ADD, OP_AND: begin
            if (ir[5]) begin
               opb = {{11{ir[4]}}, ir[4:0]};
            end else begin
               opb = sr2_data;
            end
         end
         default: opb = 16'h0000;
      endcase
   end

endmodule

// File: rtl/alu_op_sequencer.sv
// Sequences one LC-3 ADD/AND/NOT at a time: accept, read operands, drive the external alu
// for ALU_LAT cycles, write the result back and update the architectural condition codes.
module alu_op_sequencer
   import alu_op_sequencer_pkg::*;
#(
   parameter int unsigned ALU_LAT = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] instr,
   input  logic        instr_valid,
   output logic        instr_ready,
   output logic [2:0]  sr1_addr,
   output logic [2:0]  sr2_addr,
   input  logic [15:0] sr1_data,
   input  logic [15:0] sr2_data,
   output logic [15:0] alu_a,
   output logic [15:0] alu_b,
   output logic [3:0]  alu_opcode,
   input  logic [15:0] alu_out,
   input  logic [2:0]  alu_nzp,
   output logic        wb_en,
   output logic [2:0]  wb_addr,
   output logic [15:0] wb_data,
   output logic [2:0]  cc_nzp,
   output logic        done,
   output logic        err
);

   localparam logic [2:0] LAT_INIT = 3'(ALU_LAT - 1);

   seq_state_e  state_r;
   seq_state_e  state_s;
   logic [15:0] ir_r;
   logic [15:0] alu_a_r;
   logic [15:0] alu_b_r;
   logic [3:0]  alu_op_r;
   logic [2:0]  cc_r;
   logic [2:0]  cnt_r;
   logic [15:0] opb_s;
   logic        legal_s;

   assign legal_s = is_legal_op(ir_r[15:12]);

   lc3_operand_b_mux u_opb_mux (
      .ir       (ir_r),
      .sr2_data (sr2_data),
      .opb      (opb_s)
   );

   // state register plus instruction, operand, latency counter and condition-code registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= ST_IDLE;
         ir_r     <= 16'h0000;
         alu_a_r  <= 16'h0000;
         alu_b_r  <= 16'h0000;
         alu_op_r <= 4'b0000;
         cc_r     <= NZP_RESET;
         cnt_r    <= 3'd0;
      end else begin
         state_r <= state_s;
         case (state_r)
            ST_IDLE: begin
               if (instr_valid) begin
                  ir_r <= instr;
               end
            end
            ST_DECODE: begin
               // operands are captured here, so a DR that aliases SR1/SR2 is harmless
               if (legal_s) begin
                  alu_a_r  <= sr1_data;
                  alu_b_r  <= opb_s;
                  alu_op_r <= ir_r[15:12];
                  cnt_r    <= LAT_INIT;
               end
            end
            ST_EXEC: begin
               if (cnt_r != 3'd0) begin
                  cnt_r <= cnt_r - 3'd1;
               end
            end
            ST_WB: cc_r <= alu_nzp;
            default: state_r <= ST_IDLE;
         endcase
      end
   end

   // next-state decode
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (instr_valid) begin
               state_s = ST_DECODE;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_DECODE: begin
            if (legal_s) begin
               state_s = ST_EXEC;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_EXEC: begin
            if (cnt_r == 3'd0) begin
               state_s = ST_WB;
            end else begin
               state_s = ST_EXEC;
            end
         end
         ST_WB:   state_s = ST_IDLE;
         default: state_s = ST_IDLE;
      endcase
   end

   assign instr_ready = (state_r == ST_IDLE);
   assign wb_en       = (state_r == ST_WB);
   assign err         = (state_r == ST_DECODE) && !legal_s;
   assign done        = wb_en || err;
   assign wb_addr     = ir_r[11:9];
   assign wb_data     = alu_out;
   assign sr1_addr    = ir_r[8:6];
   assign sr2_addr    = ir_r[2:0];
   assign alu_a       = alu_a_r;
   assign alu_b       = alu_b_r;
   assign alu_opcode  = alu_op_r;
   assign cc_nzp      = cc_r;

endmodule
